// File: rtl/fir_decim_buf.sv
// fir_decim_buf: decimating output buffer for the direct-form FIR filter.
//
// Keeps one filter output sample in every `decim` (the first strobed sample
// after reset is kept) and queues kept samples in a first-word-fall-through
// FIFO. The consumer drains the FIFO through a valid/ready port. The filter
// is never stalled: a kept sample that finds the FIFO full, with no pop in
// the same cycle, is dropped and raises the sticky `ovf` flag.
//
// Parameters
//   width   sample width in bits (signed, two's complement)
//   decim   decimation factor, 1..256
//   depth   FIFO depth in samples, power of two, >= 2
//
// Ports
//   clk      clock
//   rst      synchronous active-high reset
//   cke      input sample strobe, qualifies din
//   din      filter output sample
//   m_valid  FIFO not empty
//   m_ready  consumer accepts m_data when m_valid && m_ready
//   m_data   FIFO head, 0 while empty
//   level    FIFO occupancy, 0..depth
//   ovf      sticky overflow flag
//   clr_ovf  clears ovf (a same-cycle overflow wins)
module fir_decim_buf #(
  parameter int unsigned width = 16,
  parameter int unsigned decim = 4,
  parameter int unsigned depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cke,
  input  logic [width-1:0]         din,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [width-1:0]         m_data,
  output logic [$clog2(depth):0]   level,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(depth);
  // A one-bit phase counter still works for decim == 1: it never leaves 0.
  localparam int unsigned PW = (decim > 1) ? $clog2(decim) : 1;
  localparam logic [PW-1:0] PhLast = PW'(decim - 1);
  localparam logic [AW:0] LevelFull = (AW + 1)'(depth);

  logic [PW-1:0]    ph_q, ph_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [width-1:0] mem_q [depth];

  logic keep;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Transfer decisions.
  always_comb begin
    keep = cke && (ph_q == '0);
    full = (level_q == LevelFull);
    pop  = m_valid && m_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a push when it is also being drained.
    push = keep && (!full || pop);
    drop = keep && full && !pop;
  end

  // Next-state logic.
  always_comb begin
    ph_d = ph_q;
    if (cke) begin
      ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
    end

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;

    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; the pointers define which entries are live. When a
  // push and pop coincide at full, wptr == rptr and the popped head slot is
  // overwritten by the new tail, which is exactly the intended result.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= din;
    end
  end

  // Outputs depend only on registered state, never on m_ready.
  always_comb begin
    m_valid = (level_q != '0);
    m_data  = m_valid ? mem_q[rptr_q] : '0;
    level   = level_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_fir_decim_buf.sv
module tb_fir_decim_buf;

  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cke;
  logic         m_ready;
  logic         clr_ovf;
  logic [W-1:0] din;

  // Three instances share the stimulus: decim 4, 3 and 1.
  logic         mv [3];
  logic [W-1:0] md [3];
  logic [3:0]   lv [3];
  logic         ov [3];

  fir_decim_buf #(.width(W), .decim(4), .depth(D)) u_d4 (
    .clk(clk), .rst(rst), .cke(cke), .din(din), .m_valid(mv[0]), .m_ready(m_ready),
    .m_data(md[0]), .level(lv[0]), .ovf(ov[0]), .clr_ovf(clr_ovf)
  );
  fir_decim_buf #(.width(W), .decim(3), .depth(D)) u_d3 (
    .clk(clk), .rst(rst), .cke(cke), .din(din), .m_valid(mv[1]), .m_ready(m_ready),
    .m_data(md[1]), .level(lv[1]), .ovf(ov[1]), .clr_ovf(clr_ovf)
  );
  fir_decim_buf #(.width(W), .decim(1), .depth(D)) u_d1 (
    .clk(clk), .rst(rst), .cke(cke), .din(din), .m_valid(mv[2]), .m_ready(m_ready),
    .m_data(md[2]), .level(lv[2]), .ovf(ov[2]), .clr_ovf(clr_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample count modulo decim, a queue of kept samples,
  // and the overflow flag.
  int                  dec [3] = '{4, 3, 1};
  int                  mcnt [3];
  bit                  movf [3];
  logic signed [W-1:0] mq [3][$];
  logic signed [W-1:0] got_q [3][$];

  task automatic model_step();
    bit pop, keep, drop;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k].delete();
        mcnt[k] = 0;
        movf[k] = 1'b0;
      end else begin
        pop  = (mq[k].size() > 0) && m_ready;
        keep = cke && (mcnt[k] == 0);
        if (cke) mcnt[k] = (mcnt[k] + 1) % dec[k];
        drop = keep && (mq[k].size() == D) && !pop;
        if (pop) void'(mq[k].pop_front());
        if (keep && !drop) mq[k].push_back($signed(din));
        if (drop) movf[k] = 1'b1;
        else if (clr_ovf) movf[k] = 1'b0;
      end
    end
  endtask

  task automatic compare();
    int exp_data;
    for (int k = 0; k < 3; k++) begin
      exp_data = (mq[k].size() > 0) ? int'(mq[k][0]) : 0;
      check($sformatf("m_valid[d%0d]", dec[k]), int'(mv[k]), int'(mq[k].size() > 0));
      check($sformatf("m_data[d%0d]", dec[k]), int'($signed(md[k])), exp_data);
      check($sformatf("level[d%0d]", dec[k]), int'(lv[k]), mq[k].size());
      check($sformatf("ovf[d%0d]", dec[k]), int'(ov[k]), int'(movf[k]));
    end
  endtask

  // One clock: log accepted outputs, advance model at the edge, then check.
  task automatic step();
    for (int k = 0; k < 3; k++) begin
      if (mv[k] && m_ready && !rst) got_q[k].push_back($signed(md[k]));
    end
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) got_q[k].delete();
  endtask

  task automatic check_list(input string tag, input int k, input int exp[$]);
    check({tag, "_count"}, got_q[k].size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q[k].size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), int'(got_q[k][i]), exp[i]);
    end
  endtask

  initial begin
    int max_lv;
    int exp_l[$];
    rst = 1'b1; cke = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0; din = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_level", int'(lv[0]), 0);
    check("reset_m_data", int'(md[0]), 0);
    for (int k = 0; k < 3; k++) got_q[k].delete();

    // Pass-through, decim 4.
    m_ready = 1'b1;
    max_lv = 0;
    for (int i = 1; i <= 12; i++) begin
      cke = 1'b1; din = W'(i);
      step();
      if (int'(lv[0]) > max_lv) max_lv = int'(lv[0]);
    end
    cke = 1'b0;
    repeat (3) step();
    check("pass_max_level", max_lv, 1);
    exp_l = '{1, 5, 9};
    check_list("pass_out", 0, exp_l);

    // Sparse strobe, decim 3.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cke = 1'b1; din = W'(-100 + i);
      step();
      cke = 1'b0;
      repeat (4) step();
    end
    exp_l = '{-100, -97, -94};
    check_list("sparse_out", 1, exp_l);

    // Fill and overflow, decim 1.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cke = 1'b1; din = W'(i);
      step();
      if (i == 8) begin
        check("fill_level", int'(lv[2]), 8);
        check("fill_ovf", int'(ov[2]), 1);
      end
    end
    cke = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_alone_ovf", int'(ov[2]), 0);
    // Push and pop together at full.
    cke = 1'b1; m_ready = 1'b1; din = W'(10);
    step();
    cke = 1'b0; m_ready = 1'b0;
    check("full_pp_level", int'(lv[2]), 8);
    check("full_pp_ovf", int'(ov[2]), 0);
    // Clear together with a dropping push: set wins.
    cke = 1'b1; clr_ovf = 1'b1; din = W'(11);
    step();
    cke = 1'b0; clr_ovf = 1'b0;
    check("clr_vs_drop_ovf", int'(ov[2]), 1);
    got_q[2].delete();
    m_ready = 1'b1;
    repeat (10) step();
    exp_l = '{1, 2, 3, 4, 5, 6, 7, 10};
    check_list("drain_out", 2, exp_l);
    check("drain_empty", int'(mv[2]), 0);

    // Mid-stream reset with level 5, phase 2 on decim 4.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cke = 1'b1; din = W'(1000 + i);
      step();
    end
    check("pre_rst_level", int'(lv[0]), 5);
    din = W'(55);
    rst = 1'b1;
    step();
    rst = 1'b0; cke = 1'b0;
    check("rst_level", int'(lv[0]), 0);
    check("rst_m_valid", int'(mv[0]), 0);
    check("rst_m_data", int'(md[0]), 0);
    check("rst_ovf_d1", int'(ov[2]), 0);
    cke = 1'b1; din = W'(77);
    step();
    cke = 1'b0;
    check("post_rst_valid", int'(mv[0]), 1);
    check("post_rst_data", int'($signed(md[0])), 77);

    // Randomized traffic with varying consumer speed.
    for (int n = 0; n < 3000; n++) begin
      int rp;
      rp = (n / 500) % 3 == 0 ? 10 : ((n / 500) % 3 == 1 ? 50 : 90);
      rst     = ($urandom_range(0, 299) == 0);
      cke     = ($urandom_range(0, 99) < 60);
      m_ready = ($urandom_range(0, 99) < rp);
      clr_ovf = ($urandom_range(0, 29) == 0);
      din     = W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_decim_buf.md
# fir_decim_buf

Downstream stage of the direct-form FIR filter: takes the filter's output sample stream (qualified by the same `cke` strobe that advances the FIR delay line), keeps one sample in every `decim`, and buffers the kept samples in a first-word-fall-through FIFO. Samples leave through a valid/ready interface to the next consumer, such as a DMA packer or a UART/streaming sink. Back-pressure never stalls the filter: overflow drops samples and raises a sticky flag.

## Interface
- `width`, 16, sample width in bits (signed, two's complement).
- `decim`, 4, decimation factor; legal range 1..256.
- `depth`, 8, FIFO depth in samples; power of two, at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cke`  in  1  input sample strobe; `din` is valid when `cke` is high.
- `din`  in  width  signed filter output sample.
- `m_valid`  out  1  output sample available (FIFO not empty).
- `m_ready`  in  1  consumer accepts the sample when `m_valid && m_ready`.
- `m_data`  out  width  signed output sample (FIFO head).
- `level`  out  $clog2(depth)+1  current FIFO occupancy, 0..depth.
- `ovf`  out  1  sticky overflow flag.
- `clr_ovf`  in  1  clears `ovf`.

## Operation
- Phase counter `ph`, range 0..decim-1, advances by 1 on each `cke`, wrapping from decim-1 to 0. It does not move without `cke`.
- Keep rule: the sample is kept when `cke && ph==0`. The first `cke` sample after reset is therefore kept, followed by every `decim`-th sample after it. With `decim==1`, every `cke` sample is kept.
- Push: a kept sample is written at the tail of the FIFO.
- Pop: when `m_valid && m_ready`, the head entry is removed.
- Full FIFO:
  - If a keep occurs in the same cycle as a pop, both happen; `level` is unchanged.
  - If a keep occurs without a pop, the sample is dropped, `ovf` is set, and the FIFO contents and `level` are unchanged.
- Empty FIFO: a pop cannot occur because `m_valid` is 0. A push into an empty FIFO is not bypassed combinationally to the output.
- `level` rules:
  - Increments on a push without a pop.
  - Decrements on a pop without a push.
  - Stays the same otherwise.
  - Never exceeds `depth` and never goes below 0.
- `ovf` is cleared by `clr_ovf`. If `clr_ovf` and a new overflow occur in the same cycle, the set wins and `ovf` stays 1.
- `m_data` equals the FIFO head while `m_valid` is 1, and is forced to 0 when the FIFO is empty.
- Data passes through unmodified: no rounding, scaling or sign change.
- Pointers are log2(depth) bits wide and wrap naturally.

## Timing
- Reset values: `ph`=0, `level`=0, `m_valid`=0, `m_data`=0, `ovf`=0, and both read and write pointers = 0.
- A reset asserted mid-stream discards all buffered samples and clears `ovf` on the next edge. Samples presented during reset are ignored.
- Latency: a sample kept at edge N appears on `m_data` with `m_valid`=1 after edge N when the FIFO was empty, i.e. one cycle from `cke` to `m_valid`.
- After a pop at edge N, the next entry (or 0 / `m_valid`=0 if the FIFO is now empty) is visible after edge N.
- `m_valid` must not depend combinationally on `m_ready`.
- `m_data` must hold stable while `m_valid && !m_ready`.
- Sustained throughput: one pop per cycle and one push per cycle.
- All outputs are registered or derived from registered state only.

## Test plan
- Reset and pass-through:
  - Stimulus: `decim`=4, `m_ready`=1, `cke` every cycle, `din` = 1, 2, 3, …, 12.
  - Required: outputs 1, 5, 9, each with `m_valid` for exactly 1 cycle, one cycle after its input; `level` never exceeds 1.
- Sparse strobe:
  - Stimulus: `decim`=3, `cke` every 5th cycle, `din` = -100, -99, ….
  - Required: outputs -100, -97, -94; `ph` advances only on `cke`.
- Fill and overflow:
  - Stimulus: `depth`=8, `decim`=1, `m_ready`=0, 10 `cke` samples 0..9.
  - Required: `level`=8, `ovf`=1 after the 9th sample. Draining with `m_ready`=1 then yields 0..7 in order and `m_valid`=0 afterwards.
- Simultaneous push and pop at full:
  - Stimulus: FIFO full; one cycle with both `cke` and `m_ready`.
  - Required: head popped, new sample appended, `level` stays 8, `ovf` stays 0.
- Overflow clear priority:
  - Stimulus: with `ovf`=1, assert `clr_ovf` alone.
  - Required: `ovf`=0 next cycle.
  - Stimulus: assert `clr_ovf` together with a dropping push.
  - Required: `ovf`=1.
- Mid-stream reset:
  - Stimulus: `rst` pulse with `level`=5 and `ph`=2.
  - Required: next cycle `level`=0, `m_valid`=0, `m_data`=0, `ovf`=0; the first `cke` sample after reset is kept.
